// File: rtl/game_timer_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// game_timer_ctrl_pkg : shared game-timer types and constants   rev 1.0
// ----------------------------------------------------------------------
package game_timer_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    RUN     = 3'd2,
    PAUSE   = 3'd3,
    EXPIRED = 3'd4
  } state_t;

  localparam int BONUS_SECS = 10;
  localparam int TIMER_MAX  = 99;

endpackage
`default_nettype wire

// File: rtl/game_timer_ctrl_sec_prescaler.sv
`default_nettype none
// ----------------------------------------------------------------------
// sec_prescaler : free-running second divider with hold and clear  rev 1.0
// ----------------------------------------------------------------------
module sec_prescaler #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int PRESC_W       = 26
) (
  input  logic clk,
  input  logic resetN,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam logic [PRESC_W-1:0] c_last = PRESC_W'(TICKS_PER_SEC - 1);

  logic [PRESC_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (run) begin
      r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + PRESC_W'(1);
    end
  end

  // High in the cycle the counter wraps; the parent registers it as the tick.
  assign tick = run && !clear && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/game_timer_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------
// game_timer_ctrl : load/tick/bonus/pause sequencer for BCD timer  rev 1.0
// ----------------------------------------------------------------------
module game_timer_ctrl
  import game_timer_ctrl_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int PRESC_W       = 26,
  parameter int WARN_SECS     = 10,
  parameter int PEND_W        = 3
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       start_game,
  input  logic       pause_req,
  input  logic       bonus_a,
  input  logic       bonus_b,
  input  logic [3:0] timer_countL,
  input  logic [3:0] timer_countH,
  input  logic       timer_tc,
  output logic       timer_loadN,
  output logic       timer_en1,
  output logic       timer_en2,
  output logic       timer_inc,
  output logic       time_up,
  output logic       low_time,
  output logic       running
);

  localparam logic [PEND_W+1:0] c_pend_max = (PEND_W+2)'((1 << PEND_W) - 1);
  localparam logic [6:0]        c_warn     = 7'(WARN_SECS);

  state_t              r_state, w_state_nxt;
  logic [PEND_W-1:0]   r_pend, w_pend_nxt;
  logic [PEND_W+1:0]   w_pend_sum;
  logic [1:0]          w_add;
  logic [6:0]          w_remain;
  logic                w_accept, w_expire, w_issue, w_run, w_clear, w_tick;
  logic                w_loadN, w_en2, w_time_up, w_low, w_running;

  assign w_accept = ((r_state == RUN) || (r_state == PAUSE)) && !start_game;
  assign w_add    = {1'b0, bonus_a & w_accept} + {1'b0, bonus_b & w_accept};
  // A fresh or outstanding bonus keeps the game alive at terminal count.
  assign w_expire = timer_tc && (r_pend == '0) && !timer_inc && (w_add == 2'd0);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (start_game) begin
      w_state_nxt = LOAD;
    end else begin
      unique case (r_state)
        IDLE:    w_state_nxt = IDLE;
        LOAD:    w_state_nxt = pause_req ? PAUSE : RUN;
        RUN: begin
          if (pause_req)     w_state_nxt = PAUSE;
          else if (w_expire) w_state_nxt = EXPIRED;
          else               w_state_nxt = RUN;
        end
        PAUSE:   w_state_nxt = pause_req ? PAUSE : RUN;
        EXPIRED: w_state_nxt = EXPIRED;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign w_run   = (w_state_nxt == RUN);
  assign w_clear = start_game || (r_state == LOAD);

  sec_prescaler #(
    .TICKS_PER_SEC (TICKS_PER_SEC),
    .PRESC_W       (PRESC_W)
  ) u_sec_prescaler (
    .clk    (clk),
    .resetN (resetN),
    .clear  (w_clear),
    .run    (w_run),
    .tick   (w_tick)
  );

  // Ticks win over incs; back-to-back incs are spaced so the count settles.
  assign w_issue = (r_state == RUN) && w_run && (r_pend != '0) && !w_tick && !timer_inc;

  assign w_pend_sum = {2'b00, r_pend} + {{PEND_W{1'b0}}, w_add}
                    - {{(PEND_W+1){1'b0}}, w_issue};
  assign w_pend_nxt = (w_pend_sum > c_pend_max) ? c_pend_max[PEND_W-1:0]
                                                : w_pend_sum[PEND_W-1:0];

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)                                          r_pend <= '0;
    else if (w_clear || (r_state == EXPIRED) || (r_state == IDLE)) r_pend <= '0;
    else                                                  r_pend <= w_pend_nxt;
  end

  assign w_remain = ({3'b000, timer_countH} * 7'd10) + {3'b000, timer_countL};

  always_comb begin
    w_loadN   = (w_state_nxt != LOAD);
    w_en2     = w_run;
    w_running = w_run;
    w_time_up = (w_state_nxt == EXPIRED);
    w_low     = ((w_state_nxt == RUN) || (w_state_nxt == PAUSE)) && !timer_tc
              && (w_remain <= c_warn);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      timer_loadN <= 1'b1;
      timer_en1   <= 1'b0;
      timer_en2   <= 1'b0;
      timer_inc   <= 1'b0;
      time_up     <= 1'b0;
      low_time    <= 1'b0;
      running     <= 1'b0;
    end else begin
      timer_loadN <= w_loadN;
      timer_en1   <= w_tick;
      timer_en2   <= w_en2;
      timer_inc   <= w_issue;
      time_up     <= w_time_up;
      low_time    <= w_low;
      running     <= w_running;
    end
  end

endmodule
`default_nettype wire

// File: doc/game_timer_ctrl.md
Name: game_timer_ctrl

Overview:
- Sequencer for the BCD game countdown timer.
- Generates the 1 Hz count enable, issues the load on game start, and serialises "+10 s" bonus pickups into single-cycle inc_time pulses.
- Handles pause/resume and detects timeout from the timer's terminal count.
- Sits between the game-state logic and the timer instance; its outputs drive the timer's loadN, enable1, enable2 and inc_time pins directly.

Parameters:
- TICKS_PER_SEC, 50_000_000, clk cycles per game second (benches use 4)
- PRESC_W, 26, prescaler counter width; must hold TICKS_PER_SEC-1
- WARN_SECS, 10, remaining-time threshold (inclusive) for low_time
- PEND_W, 3, width of bonus pending counter; saturates at 2^PEND_W-1

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- start_game  in  1  1-cycle pulse: (re)load timer and start counting
- pause_req  in  1  level: 1 = freeze timer
- bonus_a  in  1  1-cycle pulse: player A picked up a time bonus
- bonus_b  in  1  1-cycle pulse: player B picked up a time bonus
- timer_countL  in  4  timer BCD ones digit
- timer_countH  in  4  timer BCD tens digit
- timer_tc  in  1  timer terminal count (both digits zero)
- timer_loadN  out  1  active-low load to timer
- timer_en1  out  1  one-second tick (1-cycle pulse)
- timer_en2  out  1  run gate, 1 only in RUN
- timer_inc  out  1  1-cycle "+10 s" request to timer
- time_up  out  1  level, 1 in EXPIRED
- low_time  out  1  level warning
- running  out  1  1 in RUN

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, resetN.
- Reset state:
  - State = IDLE, prescaler = 0, pending = 0.
  - timer_loadN = 1, timer_en1 = 0, timer_en2 = 0, timer_inc = 0, time_up = 0, low_time = 0, running = 0.
- All outputs are registered.
- FSM states: IDLE, LOAD, RUN, PAUSE, EXPIRED.
- IDLE:
  - Outputs are inactive.
  - start_game -> LOAD.
- LOAD (exactly 1 cycle):
  - timer_loadN = 0.
  - Prescaler and pending are cleared.
  - Next state is PAUSE if pause_req = 1, else RUN.
- start_game in any state -> LOAD. This has the highest priority and also clears pending.
- RUN:
  - timer_en2 = 1, running = 1.
  - The prescaler counts 0..TICKS_PER_SEC-1 and wraps. timer_en1 = 1 for exactly the cycle after the prescaler reaches TICKS_PER_SEC-1.
  - pause_req = 1 -> PAUSE.
  - timer_tc = 1 with no inc being issued -> EXPIRED.
- PAUSE:
  - Prescaler holds its value; no en1, no inc. timer_en2 = 0.
  - pause_req = 0 -> RUN.
  - Resuming continues the partial second; it does not restart it.
- EXPIRED:
  - time_up = 1, all timer controls are inactive, bonuses are ignored, pending is cleared.
  - Only start_game leaves this state.
- Bonus handling:
  - Each cycle, pending += bonus_a + bonus_b, saturating at max.
  - Bonuses are accepted in RUN and PAUSE, and ignored in IDLE and EXPIRED.
  - A bonus arriving in the same cycle as start_game is discarded.
- Issue rule:
  - In RUN, with pending > 0 and no en1 on the next cycle, and no inc on the previous cycle: timer_inc = 1 for 1 cycle and pending decrements.
  - The tick is never suppressed; an inc that would collide with it is deferred.
  - Consecutive incs are at least 2 cycles apart so the timer count settles.
  - An accept and an issue in the same cycle net correctly.
- Expiry interaction: if timer_tc = 1 while pending > 0 in RUN, an inc is issued and expiry is suppressed. The timer saturates at 99.
- low_time:
  - Registered. Equals 1 when state is RUN or PAUSE, timer_tc = 0, and (timer_countH*10 + timer_countL) <= WARN_SECS.
  - Arithmetic is done in 7 bits unsigned.
- Reset mid-operation returns every output to its reset value asynchronously, in any state.

Decomposition:
- Shared game package holds:
  - the state enum type (typedef enum logic [2:0]) with the names above;
  - the constants BONUS_SECS = 10 and TIMER_MAX = 99.
- One sub-module, sec_prescaler:
  - Parameterised counter with inputs clk, resetN, clear, run, and output tick.
  - Holds its value when run = 0.

Test Plan:
1. Reset, then start_game with TICKS_PER_SEC=4 and a timer model loaded with 99 -> timer_loadN low 1 cycle; timer_en1 pulses every 4 cycles; the model reads 98 after the first tick.
2. Pause 2 cycles into a second, hold 20 cycles, then release -> no en1 while paused; next en1 arrives 2 cycles after release.
3. bonus_a and bonus_b in the same cycle at count 45 -> two timer_inc pulses at least 2 cycles apart, neither on an en1 cycle; model reaches 65 minus elapsed ticks.
4. Bonus when count = 95 -> inc issued; model saturates at 99; pending returns to 0.
5. Let the count run to 00 with no pending -> low_time asserts at 10; at tc, state = EXPIRED, time_up = 1, en2 = 0; a bonus is ignored; start_game reloads 99 and clears time_up.
6. Assert resetN low mid-RUN with pending = 3 -> all outputs 0 and loadN = 1 immediately; after release, state is IDLE and no inc is issued.
